// File: rtl/ps2_pkg.sv
// Shared PS/2 constants, frame-FSM state encoding and parity helper.
// No logic of its own; imported by the receiver and the key decoder.
// Not applicable: holds no flow-controlled path.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  localparam logic [7:0] KEY_S   = 8'h1B;
  localparam logic [7:0] KEY_R   = 8'h2D;
  localparam logic [7:0] KEY_P   = 8'h4D;
  localparam logic [7:0] KEY_ESC = 8'h76;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } frame_state_t;

  // PS/2 uses odd parity: data bits plus the parity bit hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: pin synchronizers, ps2_clk glitch filter, frame FSM and timeout.
// byte_valid/byte_err are combinational pulses in the cycle of the filtered stop/error fall.
// No backpressure: the keyboard cannot be stalled, every byte is presented exactly once.
module ps2_frame_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 200_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       byte_err
);
  import ps2_pkg::*;

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  logic [1:0]    clk_sync;
  logic [1:0]    data_sync;
  logic          clk_s;
  logic          data_s;
  logic          clk_filt;
  logic [FW-1:0] filt_cnt;
  logic          filt_flip;
  logic          fall;

  frame_state_t  state;
  frame_state_t  state_nxt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit;

  // Idle PS/2 lines are high, so synchronizers reset to 1 to avoid a spurious fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
    end
  end

  assign clk_s  = clk_sync[1];
  assign data_s = data_sync[1];

  // The filtered clock only moves after FILTER_LEN consecutive disagreeing samples.
  assign filt_flip = (clk_s != clk_filt) && (filt_cnt == FW'(FILTER_LEN - 1));
  assign fall      = filt_flip && !clk_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_filt <= 1'b1;
      filt_cnt <= '0;
    end else if (clk_s == clk_filt) begin
      filt_cnt <= '0;
    end else if (filt_flip) begin
      clk_filt <= clk_s;
      filt_cnt <= '0;
    end else begin
      filt_cnt <= filt_cnt + 1'b1;
    end
  end

  assign tmo_hit = (state != ST_IDLE) && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    byte_valid = 1'b0;
    byte_err   = 1'b0;
    if (fall) begin
      case (state)
        ST_IDLE: begin
          if (data_s) begin
            byte_err = 1'b1;
          end else begin
            state_nxt = ST_DATA;
          end
        end
        ST_DATA: begin
          if (bit_cnt == 3'd7) begin
            state_nxt = ST_PARITY;
          end
        end
        ST_PARITY: begin
          if (odd_parity_ok(shreg, data_s)) begin
            state_nxt = ST_STOP;
          end else begin
            byte_err  = 1'b1;
            state_nxt = ST_IDLE;
          end
        end
        ST_STOP: begin
          state_nxt  = ST_IDLE;
          byte_valid = data_s;
          byte_err   = !data_s;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end else if (tmo_hit) begin
      byte_err  = 1'b1;
      state_nxt = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0;
      shreg   <= '0;
      tmo_cnt <= '0;
    end else begin
      if (fall && state == ST_IDLE) begin
        bit_cnt <= '0;
      end
      // LSB arrives first, so shift in from the top.
      if (fall && state == ST_DATA) begin
        shreg   <= {data_s, shreg[7:1]};
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (state == ST_IDLE || fall) begin
        tmo_cnt <= '0;
      end else begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
    end
  end

  assign byte_data = shreg;

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: decodes scan-code set 2 make/break/E0 sequences into a held key_code.
// key_valid and qualifiers pulse one cycle after the filtered stop-bit fall; frame_err likewise.
// No backpressure: events are single-cycle pulses, key_code is a level for the consumer.
module ps2_keyboard_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 200_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] key_code,
  output logic       key_valid,
  output logic       key_break,
  output logic       key_extended,
  output logic       frame_err
);
  import ps2_pkg::*;

  logic [7:0] byte_data;
  logic       byte_valid;
  logic       byte_err;
  logic       ext_flag;
  logic       brk_flag;

  ps2_frame_rx #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_frame_rx (
    .clk       (clk),
    .rst_n     (rst_n),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .byte_data (byte_data),
    .byte_valid(byte_valid),
    .byte_err  (byte_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_code     <= 8'h00;
      key_valid    <= 1'b0;
      key_break    <= 1'b0;
      key_extended <= 1'b0;
      frame_err    <= 1'b0;
      ext_flag     <= 1'b0;
      brk_flag     <= 1'b0;
    end else begin
      key_valid    <= 1'b0;
      key_break    <= 1'b0;
      key_extended <= 1'b0;
      frame_err    <= byte_err;
      if (byte_err) begin
        ext_flag <= 1'b0;
        brk_flag <= 1'b0;
      end else if (byte_valid) begin
        case (byte_data)
          PS2_EXT: ext_flag <= 1'b1;
          PS2_BRK: brk_flag <= 1'b1;
          default: begin
            key_valid    <= 1'b1;
            key_break    <= brk_flag;
            key_extended <= ext_flag;
            ext_flag     <= 1'b0;
            brk_flag     <= 1'b0;
            // Releasing a key other than the held one leaves the held key alone.
            if (!brk_flag) begin
              key_code <= byte_data;
            end else if (byte_data == key_code) begin
              key_code <= 8'h00;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Bench for ps2_keyboard_rx: directed frame table, glitch/timeout/reset sequences, random frames vs byte-level model.
module tb_ps2_keyboard_rx;
  import ps2_pkg::*;

  localparam int FL = 8;
  localparam int TO = 1000;
  localparam int HP = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] key_code;
  logic       key_valid;
  logic       key_break;
  logic       key_extended;
  logic       frame_err;

  always #5 clk = ~clk;

  ps2_keyboard_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .key_break   (key_break),
    .key_extended(key_extended),
    .frame_err   (frame_err)
  );

  int   checks = 0;
  int   errors = 0;
  int   nv = 0;
  int   ne = 0;
  int   nboth = 0;
  int   nstray = 0;
  logic lb = 1'b0;
  logic le = 1'b0;

  always @(negedge clk) begin
    if (key_valid) begin
      nv++;
      lb = key_break;
      le = key_extended;
    end
    if (frame_err) ne++;
    if (key_valid && frame_err) nboth++;
    if (!key_valid && (key_break || key_extended)) nstray++;
  end

  // err is the number of frame_err pulses the frame should cause.
  typedef struct {
    logic [7:0] b;
    bit         bad;
    bit         v;
    bit         brk;
    bit         ext;
    logic [7:0] code;
    int         err;
  } vec_t;

  vec_t vecs[$];

  bit         m_ext = 0;
  bit         m_brk = 0;
  logic [7:0] m_code = 8'h00;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic d, input bit glitch);
    ps2_data = d;
    wait_cyc(HP / 2);
    if (glitch) begin
      ps2_clk = 1'b0;
      wait_cyc(1 + $urandom_range(0, 2));
      ps2_clk = 1'b1;
    end
    wait_cyc(HP / 2);
    ps2_clk = 1'b0;
    wait_cyc(HP / 2);
    if (glitch) begin
      ps2_clk = 1'b1;
      wait_cyc(2);
      ps2_clk = 1'b0;
    end
    wait_cyc(HP / 2);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad, input bit glitch);
    logic p;
    p = (~^b) ^ bad;
    send_bit(1'b0, glitch);
    for (int i = 0; i < 8; i++) send_bit(b[i], glitch);
    send_bit(p, glitch);
    send_bit(1'b1, glitch);
    wait_cyc(2 * HP);
  endtask

  // Byte-level behaviour; a bad-parity frame errors at parity, then its stop bit lands in IDLE as a second error.
  task automatic model(input logic [7:0] b, input bit bad, output vec_t e);
    e.b = b; e.bad = bad; e.v = 0; e.brk = 0; e.ext = 0; e.err = 0;
    if (bad) begin
      e.err = 2;
      m_ext = 0;
      m_brk = 0;
    end else if (b == 8'hE0) begin
      m_ext = 1;
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else begin
      e.v = 1; e.brk = m_brk; e.ext = m_ext;
      if (!m_brk) m_code = b;
      else if (m_code == b) m_code = 8'h00;
      m_ext = 0;
      m_brk = 0;
    end
    e.code = m_code;
  endtask

  task automatic run_frame(input string nm, input vec_t e, input bit glitch);
    int v0;
    int e0;
    v0 = nv;
    e0 = ne;
    send_frame(e.b, e.bad, glitch);
    check({nm, "_valid_cnt"}, nv - v0, e.v);
    check({nm, "_err_cnt"}, ne - e0, e.err);
    if (e.v) begin
      check({nm, "_break"}, lb, e.brk);
      check({nm, "_ext"}, le, e.ext);
    end
    check({nm, "_code"}, key_code, e.code);
  endtask

  initial begin
    vec_t e;
    int   v0;
    int   e0;
    logic [7:0] b;
    bit   bad;

    vecs.push_back('{8'h1B, 0, 1, 0, 0, 8'h1B, 0});
    vecs.push_back('{8'hF0, 0, 0, 0, 0, 8'h1B, 0});
    vecs.push_back('{8'h1B, 0, 1, 1, 0, 8'h00, 0});
    vecs.push_back('{8'h76, 0, 1, 0, 0, 8'h76, 0});
    vecs.push_back('{8'h4D, 0, 1, 0, 0, 8'h4D, 0});
    vecs.push_back('{8'hF0, 0, 0, 0, 0, 8'h4D, 0});
    vecs.push_back('{8'h76, 0, 1, 1, 0, 8'h4D, 0});
    vecs.push_back('{8'hF0, 0, 0, 0, 0, 8'h4D, 0});
    vecs.push_back('{8'h4D, 0, 1, 1, 0, 8'h00, 0});
    vecs.push_back('{8'hE0, 0, 0, 0, 0, 8'h00, 0});
    vecs.push_back('{8'h75, 0, 1, 0, 1, 8'h75, 0});
    vecs.push_back('{8'hE0, 0, 0, 0, 0, 8'h75, 0});
    vecs.push_back('{8'hF0, 0, 0, 0, 0, 8'h75, 0});
    vecs.push_back('{8'h75, 0, 1, 1, 1, 8'h00, 0});
    vecs.push_back('{8'h1B, 0, 1, 0, 0, 8'h1B, 0});
    vecs.push_back('{8'h2D, 1, 0, 0, 0, 8'h1B, 2});
    vecs.push_back('{8'hF0, 0, 0, 0, 0, 8'h1B, 0});
    vecs.push_back('{8'h2D, 0, 1, 1, 0, 8'h1B, 0});
    vecs.push_back('{8'hF0, 0, 0, 0, 0, 8'h1B, 0});
    vecs.push_back('{8'hE0, 0, 0, 0, 0, 8'h1B, 0});
    vecs.push_back('{8'h1B, 0, 1, 1, 1, 8'h00, 0});
    vecs.push_back('{8'hE0, 0, 0, 0, 0, 8'h00, 0});
    vecs.push_back('{8'hE0, 0, 0, 0, 0, 8'h00, 0});
    vecs.push_back('{8'h74, 0, 1, 0, 1, 8'h74, 0});
    vecs.push_back('{8'h74, 0, 1, 0, 0, 8'h74, 0});
    vecs.push_back('{8'hE0, 0, 0, 0, 0, 8'h74, 0});
    vecs.push_back('{8'h2D, 1, 0, 0, 0, 8'h74, 2});
    vecs.push_back('{8'h1C, 0, 1, 0, 0, 8'h1C, 0});
    vecs.push_back('{8'hF0, 0, 0, 0, 0, 8'h1C, 0});
    vecs.push_back('{8'hE0, 0, 0, 0, 0, 8'h1C, 0});
    vecs.push_back('{8'hE0, 0, 0, 0, 0, 8'h1C, 0});
    vecs.push_back('{8'h1C, 0, 1, 1, 1, 8'h00, 0});

    wait_cyc(5);
    check("rst_key_code", key_code, 8'h00);
    check("rst_key_valid", key_valid, 1'b0);
    check("rst_key_break", key_break, 1'b0);
    check("rst_key_extended", key_extended, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    rst_n = 1'b1;
    wait_cyc(5);

    foreach (vecs[i]) begin
      model(vecs[i].b, vecs[i].bad, e);
      run_frame($sformatf("vec%0d", i), vecs[i], 1'b0);
    end

    // Sub-FILTER_LEN glitches on both phases of every bit.
    model(KEY_R, 0, e);
    run_frame("glitch", e, 1'b1);
    check("glitch_code_lit", key_code, 8'h2D);

    // Pending E0, then a frame that stalls after 4 data bits.
    model(PS2_EXT, 0, e);
    run_frame("pre_tmo_e0", e, 1'b0);
    v0 = nv;
    e0 = ne;
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
    wait_cyc(2 * TO);
    check("tmo_err_cnt", ne - e0, 1);
    check("tmo_valid_cnt", nv - v0, 0);
    m_ext = 0;
    m_brk = 0;
    model(KEY_S, 0, e);
    run_frame("after_tmo", e, 1'b0);

    // Reset in the middle of a frame while a key is held.
    e0 = ne;
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    rst_n = 1'b0;
    wait_cyc(3);
    check("midrst_key_code", key_code, 8'h00);
    check("midrst_frame_err", frame_err, 1'b0);
    wait_cyc(2);
    rst_n = 1'b1;
    m_ext = 0;
    m_brk = 0;
    m_code = 8'h00;
    wait_cyc(2 * TO);
    check("midrst_err_cnt", ne - e0, 0);
    check("midrst_code_after", key_code, 8'h00);
    model(KEY_ESC, 0, e);
    run_frame("after_rst", e, 1'b0);

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 6))
        0: b = KEY_S;
        1: b = KEY_R;
        2: b = KEY_P;
        3: b = KEY_ESC;
        4: b = PS2_EXT;
        5: b = PS2_BRK;
        default: b = 8'($urandom);
      endcase
      bad = ($urandom_range(0, 9) == 0);
      model(b, bad, e);
      run_frame($sformatf("rnd%0d", n), e, 1'b0);
    end

    check("valid_and_err_same_cycle", nboth, 0);
    check("qualifier_without_valid", nstray, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
